// File: rtl/mul_pkg.sv
// Shared types and widths for the shared-multiplier arbiter.
package mul_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned PROD_W = 64;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } mul_op_t;

    // Product does not fit a 32-bit signed value when its upper 33 bits disagree.
    function automatic logic prod_ovf(input logic [PROD_W-1:0] p);
        return !((&p[PROD_W-1:DATA_W-1]) || !(|p[PROD_W-1:DATA_W-1]));
    endfunction

endpackage

// File: rtl/mul_rr_pick.sv
// Round-robin picker: first asserted request at or after ptr, wrapping.
module mul_rr_pick
    import mul_pkg::*;
#(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx
);

    logic        found;
    int unsigned k;

    // Scan NREQ positions starting at ptr; first hit wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            k = (32'(ptr) + off) % NREQ;
            if (!found && req[IDX_W'(k)]) begin
                found              = 1'b1;
                grant[IDX_W'(k)]   = 1'b1;
                idx                = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Arbitrates NREQ requesters onto one pipelined 32x32 signed multiplier.
module mul_share_arbiter
    import mul_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [NREQ-1:0]                           req_valid,
    output logic [NREQ-1:0]                           req_ready,
    input  logic [DATA_W*NREQ-1:0]                    req_a,
    input  logic [DATA_W*NREQ-1:0]                    req_b,
    output logic                                      mul_en,
    output logic [DATA_W-1:0]                         mul_a,
    output logic [DATA_W-1:0]                         mul_b,
    input  logic [PROD_W-1:0]                         mul_res,
    output logic                                      rsp_valid,
    input  logic                                      rsp_ready,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] rsp_id,
    output logic [PROD_W-1:0]                         rsp_res,
    output logic                                      rsp_ovf,
    output logic                                      busy
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   id_q, id_d;
    mul_op_t            op_q, op_d;
    logic [PROD_W-1:0]  res_q, res_d;
    logic               ovf_q, ovf_d;

    logic [NREQ-1:0]    pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic [DATA_W-1:0]  a_arr [NREQ];
    logic [DATA_W-1:0]  b_arr [NREQ];

    // Unpack the flat operand buses per requester.
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign a_arr[gi] = req_a[gi*DATA_W +: DATA_W];
        assign b_arr[gi] = req_b[gi*DATA_W +: DATA_W];
    end

    mul_rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // State and datapath registers; reset abandons any in-flight operation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            id_q    <= '0;
            op_q    <= '0;
            res_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            res_q   <= res_d;
            ovf_q   <= ovf_d;
        end
    end

    // Next-state, grant and launch logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        op_d      = op_q;
        res_d     = res_q;
        ovf_d     = ovf_q;
        req_ready = '0;
        mul_en    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!reset && (|req_valid)) begin
                    req_ready = pick_grant;
                    id_d      = pick_idx;
                    op_d.a    = a_arr[pick_idx];
                    op_d.b    = b_arr[pick_idx];
                    ptr_d     = (pick_idx == IDX_W'(NREQ - 1)) ? '0 : pick_idx + IDX_W'(1);
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                mul_en  = 1'b1;
                cnt_d   = CNT_W'(MUL_LAT);
                state_d = WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    res_d   = mul_res;
                    ovf_d   = prod_ovf(mul_res);
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mul_a     = op_q.a;
    assign mul_b     = op_q.b;
    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = id_q;
    assign rsp_res   = res_q;
    assign rsp_ovf   = ovf_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: doc/mul_share_arbiter.md
MUL_SHARE_ARBITER -- requirements
Module: mul_share_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters sharing one 32x32 signed multiplier.
REQ-002 SHALL have parameter MUL_LAT, default 2, multiplier cycles from mul_en to valid mul_res (range 1..15).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  NREQ  per-requester operation request.
REQ-006 SHALL have port req_ready  output  NREQ  one-hot accept; transfer when req_valid[i] & req_ready[i].
REQ-007 SHALL have port req_a  input  32*NREQ  signed operand A, requester i at bits [32i+31:32i].
REQ-008 SHALL have port req_b  input  32*NREQ  signed operand B, same packing.
REQ-009 SHALL have port mul_en  output  1  one-cycle launch strobe to multiplier.
REQ-010 SHALL have port mul_a, mul_b  output  32 each  operands to multiplier, held stable from launch until capture.
REQ-011 SHALL have port mul_res  input  64  signed product from multiplier.
REQ-012 SHALL have port rsp_valid  output  1  result available.
REQ-013 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-014 SHALL have port rsp_id  output  clog2(NREQ)  index of requester owning result.
REQ-015 SHALL have port rsp_res  output  64  captured product.
REQ-016 SHALL have port rsp_ovf  output  1  product not representable as 32-bit signed.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP.
REQ-019 SHALL, in IDLE with any req_valid high, assert req_ready combinationally for exactly one requester chosen round-robin, latch its operands and index, and move to ISSUE.
REQ-020 SHALL start the round-robin search at (last granted + 1) mod NREQ; after reset the search starts at index 0.
REQ-021 SHALL hold req_ready all-zero outside IDLE and in IDLE when no req_valid is high.
REQ-022 SHALL, in ISSUE, assert mul_en for one cycle, load wait counter with MUL_LAT, and move to WAIT.
REQ-023 SHALL, in WAIT, decrement the counter each cycle, capture mul_res into rsp_res on the cycle the counter reads 1, and move to RESP.
REQ-024 SHALL, in RESP, assert rsp_valid with rsp_id/rsp_res/rsp_ovf stable until rsp_ready is sampled high, then return to IDLE.
REQ-025 SHALL give rsp_valid exactly MUL_LAT+2 cycles after the accepting edge when rsp_ready is not the bottleneck; no new grant occurs in the RESP->IDLE transition cycle.
REQ-026 SHALL compute rsp_ovf = 1 when rsp_res[63:31] are not all equal.
REQ-027 SHALL ignore req_valid changes and requester operand changes after acceptance.
REQ-028 SHALL not drop a pending request: a requester holding req_valid is granted within NREQ grants.

Reset
REQ-029 SHALL, on reset, force state IDLE, req_ready 0, mul_en 0, mul_a/mul_b 0, rsp_valid 0, rsp_id 0, rsp_res 0, rsp_ovf 0, busy 0, counter 0, RR pointer 0.
REQ-030 SHALL, on reset in any state (including WAIT/RESP), abandon the in-flight operation with no response issued.

Structure
REQ-031 SHALL place state encoding (IDLE/ISSUE/WAIT/RESP) and default widths (DATA_W=32, PROD_W=64) in shared package mul_pkg.
REQ-032 SHALL implement the round-robin selection as sub-module mul_rr_pick (inputs req vector, pointer; output one-hot grant, index).

Verification
REQ-033 SHALL cover: single request i=2, A=7, B=-3, MUL_LAT=2 -> mul_en at cycle 1, rsp_valid at cycle 4, rsp_id=2, rsp_res=-21, rsp_ovf=0.
REQ-034 SHALL cover: all four req_valid held high for 8 ops -> grant order 0,1,2,3,0,1,2,3.
REQ-035 SHALL cover: A=0x7FFFFFFF, B=2 -> rsp_res=0x00000000FFFFFFFE, rsp_ovf=1; A=-65536, B=32768 -> rsp_res=-2^31, rsp_ovf=0.
REQ-036 SHALL cover: rsp_ready low for 5 cycles in RESP -> outputs stable, req_ready stays 0, single response on release.
REQ-037 SHALL cover: reset asserted during WAIT -> next cycle all outputs at reset values, no rsp_valid, next grant from index 0.
